fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch/issue block; the producer end of the decoder's COMMAND interface.
- Holds the program counter and reads 16-bit instruction words from instruction memory over a req/ack handshake.
- Presents each word on COMMAND with a valid/ready handshake to the decode/control unit.
- Applies branch redirects signalled back by the decoder on PC_load.
- Start/stop is under EXEC control; the block halts itself on HLT.

Parameters:
ADDR_W, 16, instruction address width (PC width)
DATA_W, 16, instruction word width
RESET_PC, 0, PC value after reset

Ports:
CLOCK  in  1  single system clock, rising-edge
RESET  in  1  asynchronous, active-high reset
EXEC  in  1  one-cycle start/stop pulse
mem_addr  out  ADDR_W  instruction memory address (= PC while mem_req)
mem_req  out  1  read request, held until mem_ack
mem_ack  in  1  read data valid this cycle
mem_rdata  in  DATA_W  instruction word, sampled when mem_ack=1
COMMAND  out  DATA_W  instruction word to decoder
cmd_valid  out  1  COMMAND valid
cmd_ready  in  1  decoder accepts COMMAND
PC_load  in  1  branch-taken pulse from decoder
branch_target  in  ADDR_W  redirect address, sampled with PC_load
pc  out  ADDR_W  current program counter
halted  out  1  1 when in HALT state

Behaviour:
- Reset (async, immediate): state=HALT; pc=RESET_PC; mem_addr=RESET_PC; mem_req=0; COMMAND=0; cmd_valid=0; halted=1; stop_pending=0. An outstanding memory request is abandoned; a late mem_ack is ignored.
- States: HALT, REQ, ISSUE, RESOLVE.
- HALT: halted=1. EXEC=1 -> REQ next cycle.
- REQ: mem_req=1, mem_addr=pc, held stable until mem_ack. On mem_ack: COMMAND<=mem_rdata, pc<=pc+1 (wraps 0xFFFF->0x0000, modulo 2^ADDR_W), cmd_valid<=1, go ISSUE. Fetch latency is 1 cycle after ack. Zero-wait memory (ack in the first REQ cycle) is legal.
- ISSUE: cmd_valid=1, COMMAND held stable until cmd_ready. On cmd_ready: cmd_valid<=0, go RESOLVE.
- RESOLVE (one cycle, absorbs the decoder's registered one-cycle latency):
  - PC_load=1 -> pc<=branch_target.
  - Next state is HALT if the issued word is HLT (COMMAND[15:14]==2'b11 and COMMAND[7:4]==4'b1111) or stop_pending=1; otherwise REQ.
  - Entering HALT clears stop_pending.
- PC_load outside RESOLVE is ignored (not an error).
- EXEC=1 in REQ/ISSUE/RESOLVE sets stop_pending. The in-flight instruction completes (fetch, issue, resolve) before HALT. A second EXEC while stop_pending is already set is ignored.
- EXEC coincident with mem_ack or cmd_ready: both events take effect in the same cycle.
- Throughput: one instruction per 3 cycles minimum (REQ, ISSUE, RESOLVE) with zero-wait memory and ready decoder.
- halted is a registered output equal to (state==HALT).

Optional Feature:
FETCH_SINGLE_STEP_EN
- Defined: adds input port STEP (1 bit). STEP=1 in HALT fetches and issues exactly one instruction (REQ->ISSUE->RESOLVE), then returns to HALT regardless of opcode. PC_load is still honoured in RESOLVE. STEP is ignored outside HALT. EXEC has priority if both are asserted.
- Undefined: no STEP port; behaviour exactly as above.

Decomposition:
- Shared package/include (simple_defs): state encodings (2-bit), HLT field constants (OPCLASS_ALU=2'b11, OP_HLT=4'b1111), instruction field bit positions. The decode/control unit uses the same constants.
- One natural sub-module: fetch_pc. It is the PC register with async reset to RESET_PC, increment enable, and load enable (load has priority).

Test Plan:
- Reset then EXEC pulse, memory ack 1 cycle later with words 0x0000@0, 0x4000@1 -> mem_addr 0x0000 then 0x0001; COMMAND shows each word with cmd_valid; pc=0x0002 after second issue.
- Word 0xC0F0 (HLT) fetched at 0x0005 -> issued once; halted=1 two cycles after cmd_ready; pc=0x0006; no further mem_req.
- Branch: PC_load=1 with branch_target=0x0040 in RESOLVE -> next mem_addr=0x0040. PC_load pulsed during ISSUE -> ignored, next mem_addr=pc+1.
- Backpressure: cmd_ready low for 5 cycles -> COMMAND/cmd_valid stable, no new mem_req. Memory ack delayed 4 cycles -> mem_req/mem_addr stable.
- EXEC mid-fetch at pc=0x0010 -> instruction 0x0010 still issued, then HALT with pc=0x0011. RESET asserted during REQ -> immediate mem_req=0, pc=RESET_PC, late ack ignored.
- PC wrap: pc=0xFFFF, ack -> pc=0x0000. With FETCH_SINGLE_STEP_EN: STEP pulse -> exactly one instruction issued, halted=1 again.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, HLT opcode fields, field bit positions.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package fetch_unit_pkg;

  // Fetch sequencer states; the 2-bit encoding is also visible to the decode/control unit.
  typedef enum logic [1:0] {
    ST_HALT    = 2'b00,
    ST_REQ     = 2'b01,
    ST_ISSUE   = 2'b10,
    ST_RESOLVE = 2'b11
  } fetch_state_t;

  // Instruction field positions inside a 16-bit word.
  localparam int OPCLASS_HI = 15;
  localparam int OPCLASS_LO = 14;
  localparam int OP_HI      = 7;
  localparam int OP_LO      = 4;

  // HLT is an ALU-class word with the all-ones operation code.
  localparam logic [1:0] OPCLASS_ALU = 2'b11;
  localparam logic [3:0] OP_HLT      = 4'b1111;

  // True when the word is the HLT instruction.
  function automatic logic is_hlt(input logic [15:0] word);
    return (word[OPCLASS_HI:OPCLASS_LO] == OPCLASS_ALU) &&
           (word[OP_HI:OP_LO] == OP_HLT);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: branch load or sequential increment, wraps modulo 2^ADDR_W.
// Latency: new value visible the cycle after load_en/inc_en.
// Backpressure: none; the owner decides when to advance or redirect.
module fetch_pc #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // Redirect wins over increment; the adder wraps naturally at the top of the address space.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_val;
    end else if (inc_en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue: reads words at pc over req/ack, offers them on COMMAND, applies redirects.
// Latency: COMMAND valid 1 cycle after mem_ack; 3 cycles per instruction minimum (REQ, ISSUE, RESOLVE).
// Backpressure: COMMAND held while cmd_ready is low, no new fetch meanwhile. Optional STEP port: FETCH_SINGLE_STEP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              EXEC,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic              STEP,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] COMMAND,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t state;
  logic         stop_pending;
  logic         step_start;
  logic         pc_inc;
  logic         pc_redirect;
  logic         resolve_halt;

  // A single-step start only happens when EXEC is not also asking to run freely.
`ifdef FETCH_SINGLE_STEP_EN
  assign step_start = STEP & ~EXEC;
`else
  assign step_start = 1'b0;
`endif

  // The PC only moves on a completed fetch, and only takes a branch in the resolve slot.
  assign pc_inc      = (state == ST_REQ) && mem_ack;
  assign pc_redirect = (state == ST_RESOLVE) && PC_load;

  // The address bus simply tracks pc; it only changes on ack or redirect, so it is stable under mem_req.
  assign mem_addr = pc;

  // Decision taken at the end of RESOLVE: stop on HLT or on an earlier stop/step request.
  assign resolve_halt = is_hlt(COMMAND[15:0]) || stop_pending;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .inc_en   (pc_inc),
    .load_en  (pc_redirect),
    .load_val (branch_target),
    .pc       (pc)
  );

  // Fetch sequencer with registered handshake outputs; a stop request lets the in-flight word finish.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_HALT;
      mem_req      <= 1'b0;
      COMMAND      <= '0;
      cmd_valid    <= 1'b0;
      halted       <= 1'b1;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          if (EXEC) begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
            halted  <= 1'b0;
          end else if (step_start) begin
            // Single step reuses the stop mechanism: run one word, then come back here.
            state        <= ST_REQ;
            mem_req      <= 1'b1;
            halted       <= 1'b0;
            stop_pending <= 1'b1;
          end
        end

        ST_REQ: begin
          if (EXEC) begin
            stop_pending <= 1'b1;
          end
          if (mem_ack) begin
            COMMAND   <= mem_rdata;
            cmd_valid <= 1'b1;
            mem_req   <= 1'b0;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (EXEC) begin
            stop_pending <= 1'b1;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_RESOLVE;
          end
        end

        ST_RESOLVE: begin
          if (resolve_halt) begin
            state        <= ST_HALT;
            halted       <= 1'b1;
            stop_pending <= 1'b0;
          end else begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
            // A stop requested here applies to the next instruction.
            if (EXEC) begin
              stop_pending <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        EXEC;
`ifdef FETCH_SINGLE_STEP_EN
  logic        step;
`endif
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] COMMAND;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        PC_load;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic        halted;

  fetch_unit dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .EXEC          (EXEC),
`ifdef FETCH_SINGLE_STEP_EN
    .STEP          (step),
`endif
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .COMMAND       (COMMAND),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .PC_load       (PC_load),
    .branch_target (branch_target),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;

  // Architectural model: next fetch address, pending stop, and whether the block should be halted.
  logic [15:0] mpc;
  bit          m_stop;
  bit          m_halted;

  typedef struct {
    bit          exec;
    bit          ack;
    logic [15:0] rdata;
    bit          rdy;
    bit          pl;
    logic [15:0] tgt;
    bit          e_req;
    logic [15:0] e_addr;
    bit          e_valid;
    logic [15:0] e_cmd;
    logic [15:0] e_pc;
    bit          e_halted;
  } vec_t;

  vec_t vecs[12];

  function automatic bit tb_is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk1("idle_halted", halted, 1'b1);
      chk1("idle_noreq", mem_req, 1'b0);
    end
  endtask

  // Start a run from HALT; a single-step start arms an automatic stop.
  task automatic start_run(input bit use_step);
    chk1("start_halted", halted, 1'b1);
    chk1("start_noreq", mem_req, 1'b0);
`ifdef FETCH_SINGLE_STEP_EN
    if (use_step) step = 1'b1;
    else          EXEC = 1'b1;
`else
    EXEC = 1'b1;
`endif
    tick();
    EXEC = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b0;
`endif
    m_stop   = use_step;
    m_halted = 1'b0;
    chk1("start_req", mem_req, 1'b1);
    chk16("start_addr", mem_addr, mpc);
    chk1("start_running", halted, 1'b0);
  endtask

  // One complete instruction, entered with the DUT requesting memory.
  // exec_pos: 0 none, 1 with ack, 2 during a memory wait, 3 first issue cycle, 4 resolve cycle.
  task automatic do_insn(input logic [15:0] word, input int ack_dly, input int rdy_dly,
                         input bit br, input logic [15:0] tgt, input int exec_pos, input bit spur);
    bit halting;
    for (int i = 0; i < ack_dly; i++) begin
      chk1("req_hold", mem_req, 1'b1);
      chk16("addr_hold", mem_addr, mpc);
      if (exec_pos == 2 && i == 0) begin
        EXEC   = 1'b1;
        m_stop = 1'b1;
      end
      mem_rdata = 16'($urandom);
      tick();
      EXEC = 1'b0;
    end
    chk1("req", mem_req, 1'b1);
    chk16("addr", mem_addr, mpc);
    mem_ack   = 1'b1;
    mem_rdata = word;
    if (exec_pos == 1) begin
      EXEC   = 1'b1;
      m_stop = 1'b1;
    end
    tick();
    mem_ack   = 1'b0;
    EXEC      = 1'b0;
    mem_rdata = 16'($urandom);
    mpc = mpc + 16'd1;
    chk1("cmd_valid", cmd_valid, 1'b1);
    chk16("command", COMMAND, word);
    chk16("pc_inc", pc, mpc);
    chk1("req_drop", mem_req, 1'b0);
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) begin
        chk1("valid_hold", cmd_valid, 1'b1);
        chk16("cmd_hold", COMMAND, word);
        chk1("noreq_issue", mem_req, 1'b0);
      end
      cmd_ready = (i == rdy_dly);
      if (i == 0 && exec_pos == 3) begin
        EXEC   = 1'b1;
        m_stop = 1'b1;
      end
      if (i == 0 && spur) begin
        PC_load       = 1'b1;
        branch_target = 16'($urandom);
      end
      tick();
      cmd_ready = 1'b0;
      EXEC      = 1'b0;
      PC_load   = 1'b0;
    end
    chk1("valid_drop", cmd_valid, 1'b0);
    chk1("halted_resolve", halted, 1'b0);
    halting       = tb_is_hlt(word) || m_stop;
    PC_load       = br;
    branch_target = tgt;
    if (exec_pos == 4) EXEC = 1'b1;
    tick();
    PC_load = 1'b0;
    EXEC    = 1'b0;
    if (br) mpc = tgt;
    if (halting)            m_stop = 1'b0;
    else if (exec_pos == 4) m_stop = 1'b1;
    m_halted = halting;
    chk1("halted_after", halted, halting);
    chk16("pc_after", pc, mpc);
    chk1("req_after", mem_req, !halting);
    if (!halting) chk16("addr_after", mem_addr, mpc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          ad, rd, ep;
    bit          b, sp;

    RESET = 1'b1; EXEC = 1'b0; mem_ack = 1'b0; cmd_ready = 1'b0; PC_load = 1'b0;
    mem_rdata = '0; branch_target = '0;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b0;
`endif
    mpc = 16'h0000; m_stop = 1'b0; m_halted = 1'b1;

    // Directed program: two words, backpressure, redirect, then HLT and a stray ack.
    //             exec ack  rdata     rdy pl tgt       req addr      vld cmd       pc        hlt
    vecs[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000,1'b0};
    vecs[1]  = '{1'b0,1'b1,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h0000,16'h0001,1'b0};
    vecs[2]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0001,1'b0};
    vecs[3]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0001,1'b0,16'h0000,16'h0001,1'b0};
    vecs[4]  = '{1'b0,1'b1,16'h4000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h4000,16'h0002,1'b0};
    vecs[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h4000,16'h0002,1'b0};
    vecs[6]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0002,1'b0};
    vecs[7]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0040, 1'b1,16'h0040,1'b0,16'h0000,16'h0040,1'b0};
    vecs[8]  = '{1'b0,1'b1,16'hC0F0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'hC0F0,16'h0041,1'b0};
    vecs[9]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0041,1'b0};
    vecs[10] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0041,1'b1};
    vecs[11] = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0041,1'b1};

    #12;
    chk1("rst_halted", halted, 1'b1);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_valid", cmd_valid, 1'b0);
    chk16("rst_cmd", COMMAND, 16'h0000);
    chk16("rst_pc", pc, 16'h0000);
    chk16("rst_addr", mem_addr, 16'h0000);
    tick();
    RESET = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      EXEC = vecs[i].exec; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      cmd_ready = vecs[i].rdy; PC_load = vecs[i].pl; branch_target = vecs[i].tgt;
      tick();
      EXEC = 1'b0; mem_ack = 1'b0; cmd_ready = 1'b0; PC_load = 1'b0;
      chk1("t_req", mem_req, vecs[i].e_req);
      if (vecs[i].e_req) chk16("t_addr", mem_addr, vecs[i].e_addr);
      chk1("t_valid", cmd_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) chk16("t_cmd", COMMAND, vecs[i].e_cmd);
      chk16("t_pc", pc, vecs[i].e_pc);
      chk1("t_halted", halted, vecs[i].e_halted);
    end
    mpc = 16'h0041; m_halted = 1'b1;

    // HLT at 0x0005 with slow memory and a stalled decoder.
    start_run(1'b0);
    do_insn(16'h1234, 0, 0, 1'b1, 16'h0005, 0, 1'b0);
    do_insn(16'hC0F0, 4, 5, 1'b0, 16'h0000, 0, 1'b0);
    chk16("hlt_pc", pc, 16'h0006);
    idle_check(3);

    // EXEC during a memory wait at 0x0010: word still issued, then halt at 0x0011.
    start_run(1'b0);
    do_insn(16'h0001, 0, 0, 1'b1, 16'h0010, 0, 1'b0);
    do_insn(16'h2222, 3, 0, 1'b0, 16'h0000, 2, 1'b0);
    chk1("stop_halted", halted, 1'b1);
    chk16("stop_pc", pc, 16'h0011);
    idle_check(2);

    // PC_load during ISSUE is ignored; then reset in the middle of a fetch.
    start_run(1'b0);
    do_insn(16'h0003, 1, 2, 1'b0, 16'h0000, 0, 1'b1);
    chk16("spur_addr", mem_addr, 16'h0012);
    #3;
    RESET = 1'b1;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk16("arst_pc", pc, 16'h0000);
    chk1("arst_halted", halted, 1'b1);
    chk1("arst_valid", cmd_valid, 1'b0);
    tick();
    RESET = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    chk1("late_ack_halted", halted, 1'b1);
    chk1("late_ack_valid", cmd_valid, 1'b0);
    chk1("late_ack_req", mem_req, 1'b0);
    chk16("late_ack_pc", pc, 16'h0000);
    mpc = 16'h0000; m_stop = 1'b0; m_halted = 1'b1;

    // Wrap from the top of the address space.
    start_run(1'b0);
    do_insn(16'h0000, 0, 0, 1'b1, 16'hFFFF, 0, 1'b0);
    do_insn(16'h5555, 1, 0, 1'b0, 16'h0000, 0, 1'b0);
    chk16("pc_wrap", pc, 16'h0000);

    // Randomized run against the model.
    for (int n = 0; n < 150; n++) begin
      if (m_halted) begin
        idle_check(1);
        start_run(1'b0);
      end
      w  = 16'($urandom);
      ad = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 3));
      b  = ($urandom_range(0, 3) == 0);
      ep = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      sp = ($urandom_range(0, 4) == 0);
      do_insn(w, ad, rd, b, 16'($urandom), ep, sp);
    end
    if (!m_halted) do_insn(16'hC0F0, 0, 0, 1'b0, 16'h0000, 0, 1'b0);

`ifdef FETCH_SINGLE_STEP_EN
    // STEP runs exactly one non-HLT word, then halts again.
    idle_check(1);
    start_run(1'b1);
    do_insn(16'h1111, 1, 1, 1'b0, 16'h0000, 0, 1'b0);
    chk1("step_halted", halted, 1'b1);
    idle_check(2);
    // EXEC wins over STEP: free run continues past the first word.
    EXEC = 1'b1; step = 1'b1;
    tick();
    EXEC = 1'b0; step = 1'b0;
    m_stop = 1'b0; m_halted = 1'b0;
    chk1("exec_prio_req", mem_req, 1'b1);
    do_insn(16'h2222, 0, 0, 1'b0, 16'h0000, 0, 1'b0);
    chk1("exec_prio_running", halted, 1'b0);
    do_insn(16'hC0F0, 0, 0, 1'b0, 16'h0000, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
